traffic_phase_controller: RTL and testbench

Sequencing controller for the traffic-light intersection. It consumes the one-cycle `enable` tick from the clock `Divider` and steps the two road directions through green, yellow and all-red phases, with an optional pedestrian walk phase. It sits between `Divider` and the lamp drivers, and is the only block that decides which lamps are lit.

---
 rtl/traffic_pkg.sv | 34 +++
 rtl/traffic_phase_controller_if.sv | 20 ++
 rtl/phase_timer.sv | 28 ++
 rtl/traffic_phase_controller.sv | 122 ++++++++++++
 tb/tb_traffic_phase_controller.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared phase codes, lamp encodings and phase-duration lookup for the traffic controller.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN   = 3'd0,
    NS_YELLOW  = 3'd1,
    ALL_RED_1  = 3'd2,
    EW_GREEN   = 3'd3,
    EW_YELLOW  = 3'd4,
    ALL_RED_2  = 3'd5,
    PED_WALK   = 3'd6,
    PH_ILLEGAL = 3'd7
  } phase_e;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // Counter load value for a phase: duration minus one, with a zero duration treated as one.
  function automatic int unsigned phase_dur_m1(phase_e p, int unsigned green,
                                               int unsigned yellow, int unsigned allred,
                                               int unsigned walk);
    int unsigned d;
    case (p)
      NS_GREEN, EW_GREEN:   d = green;
      NS_YELLOW, EW_YELLOW: d = yellow;
      PED_WALK:             d = walk;
      default:              d = allred;
    endcase
    if (d == 0) d = 1;
    return d - 1;
  endfunction

endpackage

// File: rtl/traffic_phase_controller_if.sv
// Tick/request inputs and lamp/phase outputs of the traffic phase controller.
interface traffic_phase_controller_if;
  logic       tick;
  logic       ped_req;
  logic       ped_ack;
  logic       walk;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic [2:0] phase;

  modport master (
    output tick, ped_req,
    input  ped_ack, walk, ns_light, ew_light, phase
  );

  modport slave (
    input  tick, ped_req,
    output ped_ack, walk, ns_light, ew_light, phase
  );
endinterface

// File: rtl/phase_timer.sv
// Down-counter timing one phase in ticks; expire fires on the tick that finds the count at zero.
module phase_timer #(
  parameter int unsigned          CNT_W   = 8,
  parameter logic [CNT_W-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             expire
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_VAL;
    end else if (load) begin
      count_q <= load_val;
    end else if (tick && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign expire = tick && (count_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// Intersection phase sequencer driven by the divider tick; pedestrian walk phase exists only
// when TRAFFIC_PED_EN is defined.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_TICKS  = 10,
  parameter int unsigned YELLOW_TICKS = 3,
  parameter int unsigned ALLRED_TICKS = 1,
  parameter int unsigned WALK_TICKS   = 5,
  parameter int unsigned CNT_W        = 8
) (
  input logic                        clk,
  input logic                        reset,
  traffic_phase_controller_if.slave  bus
);

  localparam logic [CNT_W-1:0] RST_CNT =
    CNT_W'(phase_dur_m1(ALL_RED_2, GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS, WALK_TICKS));

  phase_e           phase_q, phase_d;
  logic             expire;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [2:0]       ns_light, ew_light;

`ifdef TRAFFIC_PED_EN
  logic ped_pending_q, ped_pending_d;
  logic next_ew_q, next_ew_d;
  logic ped_ack_q, ped_ack_d;
`endif

  phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (RST_CNT)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tick     (bus.tick),
    .expire   (expire)
  );

  always_comb begin
    phase_d = phase_q;
`ifdef TRAFFIC_PED_EN
    ped_pending_d = ped_pending_q | bus.ped_req;
    next_ew_d     = next_ew_q;
    ped_ack_d     = 1'b0;
`endif
    case (phase_q)
      NS_GREEN:  if (expire) phase_d = NS_YELLOW;
      NS_YELLOW: if (expire) phase_d = ALL_RED_1;
      ALL_RED_1: if (expire) phase_d = EW_GREEN;
      EW_GREEN:  if (expire) phase_d = EW_YELLOW;
      EW_YELLOW: if (expire) phase_d = ALL_RED_2;
      ALL_RED_2: if (expire) phase_d = NS_GREEN;
`ifdef TRAFFIC_PED_EN
      PED_WALK:  if (expire) phase_d = next_ew_q ? EW_GREEN : NS_GREEN;
`endif
      default:   phase_d = ALL_RED_2;
    endcase
`ifdef TRAFFIC_PED_EN
    // A request arriving in the expiry cycle itself still diverts into the walk, and is
    // absorbed there rather than re-latched.
    if (expire && ped_pending_d && (phase_q == ALL_RED_1 || phase_q == ALL_RED_2)) begin
      next_ew_d     = (phase_q == ALL_RED_1);
      phase_d       = PED_WALK;
      ped_pending_d = 1'b0;
      ped_ack_d     = 1'b1;
    end
`endif
    load     = (phase_d != phase_q);
    load_val = CNT_W'(phase_dur_m1(phase_d, GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS,
                                   WALK_TICKS));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q       <= ALL_RED_2;
`ifdef TRAFFIC_PED_EN
      ped_pending_q <= 1'b0;
      next_ew_q     <= 1'b0;
      ped_ack_q     <= 1'b0;
`endif
    end else begin
      phase_q       <= phase_d;
`ifdef TRAFFIC_PED_EN
      ped_pending_q <= ped_pending_d;
      next_ew_q     <= next_ew_d;
      ped_ack_q     <= ped_ack_d;
`endif
    end
  end

  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    case (phase_q)
      NS_GREEN:  ns_light = LIGHT_GRN;
      NS_YELLOW: ns_light = LIGHT_YEL;
      EW_GREEN:  ew_light = LIGHT_GRN;
      EW_YELLOW: ew_light = LIGHT_YEL;
      default:   ;
    endcase
  end

  assign bus.ns_light = ns_light;
  assign bus.ew_light = ew_light;
  assign bus.phase    = phase_q;

`ifdef TRAFFIC_PED_EN
  assign bus.walk    = (phase_q == PED_WALK);
  assign bus.ped_ack = ped_ack_q;
`else
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
  assign bus.walk       = 1'b0;
  assign bus.ped_ack    = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: table-driven phase sequence plus reset, hold and
// pedestrian corner sequences, scored through an expected-result queue.
module tb_traffic_phase_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_phase_controller_if bus ();

  traffic_phase_controller #(
    .GREEN_TICKS  (4),
    .YELLOW_TICKS (2),
    .ALLRED_TICKS (1),
    .WALK_TICKS   (3),
    .CNT_W        (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] ph;
    logic       ack;
  } exp_t;

  typedef struct {
    logic       ped;
    logic [2:0] ph;
  } vec_t;

`ifdef TRAFFIC_PED_EN
  localparam bit PedEn = 1'b1;
`else
  localparam bit PedEn = 1'b0;
`endif

  exp_t sb[$];
  vec_t tbl[15];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   ack_seen = 0;
  logic ped_hold = 1'b0;

  function automatic logic [2:0] exp_ns(logic [2:0] ph);
    return (ph == 3'd0) ? 3'b001 : (ph == 3'd1) ? 3'b010 : 3'b100;
  endfunction

  function automatic logic [2:0] exp_ew(logic [2:0] ph);
    return (ph == 3'd3) ? 3'b001 : (ph == 3'd4) ? 3'b010 : 3'b100;
  endfunction

  task automatic chk(input string name, input exp_t e);
    logic [2:0] ens, eew;
    logic       ewk;
    ens = exp_ns(e.ph);
    eew = exp_ew(e.ph);
    ewk = PedEn && (e.ph == 3'd6);
    n_cmp++;
    if (bus.phase !== e.ph || bus.ns_light !== ens || bus.ew_light !== eew ||
        bus.walk !== ewk || bus.ped_ack !== e.ack) begin
      n_fail++;
      $display("FAIL %s: got ph=%0d ns=%b ew=%b walk=%b ack=%b, want ph=%0d ns=%b ew=%b walk=%b ack=%b",
               name, bus.phase, bus.ns_light, bus.ew_light, bus.walk, bus.ped_ack,
               e.ph, ens, eew, ewk, e.ack);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // One clock: sample at the falling edge, then drive the next input values.
  task automatic idle_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.ns_light !== 3'b100 && bus.ew_light !== 3'b100) begin
      n_fail++;
      $display("FAIL lamp_conflict: got ns=%b ew=%b, want at least one red",
               bus.ns_light, bus.ew_light);
    end
    if (bus.ped_ack === 1'b1) ack_seen++;
    bus.ped_req = ped_hold;
  endtask

  // One tick period of 10 clocks; checks the cycle after the tick and the one after that.
  task automatic step(input logic ped, input logic [2:0] ph, input logic ack,
                      input string name);
    exp_t e;
    e.ph  = ph;
    e.ack = ack;
    sb.push_back(e);
    bus.tick    = 1'b1;
    bus.ped_req = ped_hold | ped;
    idle_cycle();
    bus.tick = 1'b0;
    e = sb.pop_front();
    chk(name, e);
    idle_cycle();
    e.ack = 1'b0;
    chk({name, "_next"}, e);
    repeat (8) idle_cycle();
  endtask

  task automatic steps(input logic [2:0] ph, input int n, input string name);
    for (int i = 0; i < n; i++) step(1'b0, ph, 1'b0, $sformatf("%s_%0d", name, i));
  endtask

  task automatic async_reset(input string name);
    #2;
    reset       = 1'b1;
    bus.tick    = 1'b0;
    ped_hold    = 1'b0;
    bus.ped_req = 1'b0;
    #1;
    chk(name, exp_t'{3'd5, 1'b0});
    idle_cycle();
    idle_cycle();
    reset = 1'b0;
    idle_cycle();
  endtask

  initial begin
    int seq[15] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 4, 4, 5, 0};
    reset       = 1'b1;
    bus.tick    = 1'b0;
    bus.ped_req = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tbl[i].ped = 1'b0;
      tbl[i].ph  = 3'(seq[i]);
    end

    repeat (3) idle_cycle();
    chk("reset_state", exp_t'{3'd5, 1'b0});
    reset = 1'b0;
    repeat (5) idle_cycle();
    chk("post_reset_no_tick", exp_t'{3'd5, 1'b0});

    // Full cycle 5,0,1,2,3,4,5,0 with durations 1,4,2,1,4,2,1.
    for (int i = 0; i < 15; i++) step(tbl[i].ped, tbl[i].ph, 1'b0, $sformatf("cycle_%0d", i));

    // Ticks withheld: phase and counter must both freeze.
    repeat (1000) idle_cycle();
    chk("no_tick_hold", exp_t'{3'd0, 1'b0});
    steps(3'd0, 3, "held_count");
    step(1'b0, 3'd1, 1'b0, "held_count_expire");
    steps(3'd1, 1, "to_ew_y");
    step(1'b0, 3'd2, 1'b0, "to_ew_ar");
    step(1'b0, 3'd3, 1'b0, "to_ew_g");

    // Reset mid-EW_GREEN with a request pending: no walk afterwards.
    bus.ped_req = 1'b1;
    idle_cycle();
    step(1'b0, 3'd3, 1'b0, "ew_mid");
    async_reset("reset_mid_ew");
    step(1'b0, 3'd0, 1'b0, "first_green_after_reset");
    steps(3'd0, 3, "rst_ns_g");
    step(1'b0, 3'd1, 1'b0, "rst_ns_y");
    steps(3'd1, 1, "rst_ns_y_hold");
    step(1'b0, 3'd2, 1'b0, "rst_ar1");
    step(1'b0, 3'd3, 1'b0, "no_walk_after_reset");

`ifdef TRAFFIC_PED_EN
    // Single-cycle request during NS_GREEN.
    async_reset("reset_a");
    step(1'b0, 3'd0, 1'b0, "pa_ns_g");
    bus.ped_req = 1'b1;
    idle_cycle();
    steps(3'd0, 3, "pa_ns_g_hold");
    step(1'b0, 3'd1, 1'b0, "pa_ns_y");
    steps(3'd1, 1, "pa_ns_y_hold");
    step(1'b0, 3'd2, 1'b0, "pa_ar1");
    ack_seen = 0;
    step(1'b0, 3'd6, 1'b1, "pa_walk_entry");
    steps(3'd6, 2, "pa_walk");
    step(1'b0, 3'd3, 1'b0, "pa_walk_to_ew");
    chk_int("pa_ack_count", ack_seen, 1);

    // Request in the same cycle as the all-red expiry; absorbed, no second walk.
    async_reset("reset_b");
    ack_seen = 0;
    step(1'b1, 3'd6, 1'b1, "same_cycle_req");
    steps(3'd6, 2, "pb_walk");
    step(1'b0, 3'd0, 1'b0, "pb_walk_to_ns");
    steps(3'd0, 3, "pb_ns_g");
    step(1'b0, 3'd1, 1'b0, "pb_ns_y");
    steps(3'd1, 1, "pb_ns_y_hold");
    step(1'b0, 3'd2, 1'b0, "pb_ar1");
    step(1'b0, 3'd3, 1'b0, "pb_no_rewalk");
    chk_int("pb_ack_count", ack_seen, 1);

    // Request held across walk entry: one ack now, a second at the next all-red.
    async_reset("reset_c");
    step(1'b0, 3'd0, 1'b0, "pc_ns_g");
    ped_hold = 1'b1;
    steps(3'd0, 3, "pc_ns_g_hold");
    step(1'b0, 3'd1, 1'b0, "pc_ns_y");
    steps(3'd1, 1, "pc_ns_y_hold");
    step(1'b0, 3'd2, 1'b0, "pc_ar1");
    ack_seen = 0;
    step(1'b0, 3'd6, 1'b1, "pc_walk1");
    ped_hold = 1'b0;
    chk_int("pc_ack_first", ack_seen, 1);
    steps(3'd6, 2, "pc_walk1_hold");
    step(1'b0, 3'd3, 1'b0, "pc_to_ew");
    steps(3'd3, 3, "pc_ew_g");
    step(1'b0, 3'd4, 1'b0, "pc_ew_y");
    steps(3'd4, 1, "pc_ew_y_hold");
    step(1'b0, 3'd5, 1'b0, "pc_ar2");
    chk_int("pc_ack_before_second", ack_seen, 1);
    step(1'b0, 3'd6, 1'b1, "pc_walk2");
    steps(3'd6, 2, "pc_walk2_hold");
    step(1'b0, 3'd0, 1'b0, "pc_walk2_to_ns");
    chk_int("pc_ack_second", ack_seen, 2);
`else
    // Requests toggled throughout must be ignored entirely.
    async_reset("reset_noped");
    ack_seen = 0;
    for (int i = 0; i < 15; i++) begin
      ped_hold = (i % 2 == 0);
      step(1'b1, tbl[i].ph, 1'b0, $sformatf("noped_%0d", i));
    end
    chk_int("noped_ack_count", ack_seen, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
